// File: rtl/uart_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_pkg
// Values shared by the UART receiver, transmitter and the receive-side FIFO.
//   UART_DATA_W        : width of one UART character
//   UART_RX_FIFO_DEPTH : default number of entries in the receive FIFO
// No ports; imported with "import uart_rx_fifo_pkg::*;".
// ---------------------------------------------------------------------------
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_sync_fifo
// Single-clock FIFO with a show-ahead read port.
// Parameters:
//   W     : data width
//   DEPTH : number of entries, power of two, >= 2
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write request; accepted when not full, or when full and a
//                read happens on the same edge
//   wr_data    : data written on an accepted write
//   rd_en      : read request; ignored while empty
//   rd_data    : head entry, zero while empty
//   level      : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_rx_fifo_sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int  W     = UART_DATA_W,
    parameter int  DEPTH = UART_RX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   level
);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         empty;
    logic         do_wr;
    logic         do_rd;

    // Pointers carry one extra bit so that full and empty stay distinct;
    // their difference is the occupancy directly.
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    // A read frees a slot at the same edge, so a write into a full FIFO is
    // still accepted when it coincides with a read.
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Pointer update; reset empties the FIFO regardless of storage contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: nothing is visible unless the pointers say so.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Show-ahead head; forced to zero while empty so stale data never leaks.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side byte buffer behind the UART receiver. Each rising edge of the
// receiver's 'received' level pushes one byte; bytes leave on a show-ahead
// valid/ready interface. A byte arriving while full (and not popped at the
// same edge) is dropped and raises a sticky overflow flag.
// Build option:
//   UART_RX_FIFO_LEVEL_EN : when defined, adds the fill_level output.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   rx_received : receiver byte-done level
//   rx_data     : receiver byte, stable while rx_received is high
//   out_valid   : FIFO non-empty, out_data valid
//   out_data    : head byte (show-ahead), zero while empty
//   out_ready   : consumer takes the head byte when out_valid is high
//   overflow    : sticky, a byte was dropped because the FIFO was full
//   ovf_clr     : one-cycle pulse clears overflow (a drop at the same edge wins)
//   fill_level  : entries held (only with UART_RX_FIFO_LEVEL_EN)
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int  DEPTH = UART_RX_FIFO_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_received,
    input  logic [UART_DATA_W-1:0] rx_data,
    output logic                   out_valid,
    output logic [UART_DATA_W-1:0] out_data,
    input  logic                   out_ready,
    output logic                   overflow,
    input  logic                   ovf_clr
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [AW:0]            fill_level
`endif
);

    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic        rx_prev;
    logic        push;
    logic        full;
    logic        empty;
    logic        drop;
    logic [AW:0] level;

    // rx_prev comes out of reset high so that a 'received' level already
    // asserted across reset is not mistaken for a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_received;
        end
    end

    assign push = rx_received & ~rx_prev;

    assign full  = (level == LEVEL_FULL);
    assign empty = (level == '0);

    // Full implies non-empty, so a pop at this edge is just out_ready; with a
    // pop the slot frees up and the byte is kept instead of dropped.
    assign drop = push & full & ~out_ready;

    uart_rx_fifo_sync_fifo #(
        .W     (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (rx_data),
        .rd_en   (out_ready),
        .rd_data (out_data),
        .level   (level)
    );

    assign out_valid = ~empty;

    // Sticky overflow: a drop sets it even if a clear arrives at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_LEVEL_EN
    assign fill_level = level;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. A queue-based model of the buffer is
// compared against the DUT outputs every cycle, and directed scenarios add
// hand-computed expectations. fill_level is checked when the design is built
// with UART_RX_FIFO_LEVEL_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_received = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       overflow;
    logic       ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [4:0] fill_level;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         m_ovf  = 1'b0;
    bit         m_prev = 1'b1;
    logic [7:0] got[$];

    uart_rx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_received (rx_received),
        .rx_data     (rx_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr)
`ifdef UART_RX_FIFO_LEVEL_EN
        ,
        .fill_level  (fill_level)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue. Pops are applied before pushes so that a
    // full FIFO with a pop accepts the new byte; drops set the sticky flag.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_prev = 1'b1;
        end else begin
            bit do_push;
            bit dropped;
            do_push = rx_received && !m_prev;
            dropped = 1'b0;
            if (out_ready && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (do_push) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(rx_data);
                end else begin
                    dropped = 1'b1;
                end
            end
            if (dropped) begin
                m_ovf = 1'b1;
            end else if (ovf_clr) begin
                m_ovf = 1'b0;
            end
            m_prev = rx_received;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic       exp_valid;
        logic [7:0] exp_data;
        exp_valid = (mq.size() != 0);
        exp_data  = exp_valid ? mq[0] : 8'h00;
        checkOutput("cyc_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        checkOutput("cyc_data", {24'd0, out_data}, {24'd0, exp_data});
        checkOutput("cyc_ovf", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef UART_RX_FIFO_LEVEL_EN
        checkOutput("cyc_level", {27'd0, fill_level}, mq.size());
`endif
    end

    // One cycle of stimulus, driven on the falling edge.
    task automatic applyStimulus(input logic rxr, input logic [7:0] d,
                                 input logic rdy, input logic clr);
        @(negedge clk);
        rx_received = rxr;
        rx_data     = d;
        out_ready   = rdy;
        ovf_clr     = clr;
    endtask

    task automatic sendByte(input logic [7:0] d, input int hold);
        repeat (hold) applyStimulus(1'b1, d, 1'b0, 1'b0);
        applyStimulus(1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic fillBytes(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            sendByte(base + 8'(i), 3);
        end
    endtask

    // Pops everything, recording each head byte as it is accepted.
    task automatic drainAll();
        bit done;
        done = 1'b0;
        got.delete();
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            rx_received = 1'b0;
            ovf_clr     = 1'b0;
            if (!out_valid) begin
                out_ready = 1'b0;
                done      = 1'b1;
            end else begin
                got.push_back(out_data);
                out_ready = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            out_ready = 1'b0;
            $display("[TB] FAIL drain_timeout actual=%0d expected=empty", got.size());
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // 1: received level held across reset is not pushed
        #1;
        rst_n       = 1'b0;
        rx_received = 1'b1;
        rx_data     = 8'h77;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
        checkOutput("t1_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("t1_ovf", {31'd0, overflow}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

        // 2: long received level gives one entry, visible one clock later
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t2_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t2_data", {24'd0, out_data}, 32'hA5);
`ifdef UART_RX_FIFO_LEVEL_EN
        checkOutput("t2_level", {27'd0, fill_level}, 32'd1);
`endif
        repeat (30) applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t2_model_size", mq.size(), 32'd1);
        drainAll();
        checkOutput("t2_count", got.size(), 32'd1);
        if (got.size() == 1) checkOutput("t2_byte", {24'd0, got[0]}, 32'hA5);

        // 3: 17th byte dropped, overflow set, order preserved
        fillBytes(8'h01, 16);
        sendByte(8'h11, 3);
        checkOutput("t3_ovf", {31'd0, overflow}, 32'd1);
        checkOutput("t3_model_ovf", {31'd0, m_ovf}, 32'd1);
`ifdef UART_RX_FIFO_LEVEL_EN
        checkOutput("t3_level", {27'd0, fill_level}, 32'd16);
`endif
        drainAll();
        checkOutput("t3_count", got.size(), 32'd16);
        for (int i = 0; i < got.size(); i++) begin
            checkOutput("t3_order", {24'd0, got[i]}, i + 1);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t3_ovf_clr", {31'd0, overflow}, 32'd0);

        // 4: push into a full FIFO on the same edge as a pop
        fillBytes(8'h30, 16);
        applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t4_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("t4_model_size", mq.size(), 32'd16);
`ifdef UART_RX_FIFO_LEVEL_EN
        checkOutput("t4_level", {27'd0, fill_level}, 32'd16);
`endif
        drainAll();
        checkOutput("t4_count", got.size(), 32'd16);
        if (got.size() == 16) begin
            checkOutput("t4_first", {24'd0, got[0]}, 32'h31);
            checkOutput("t4_last", {24'd0, got[15]}, 32'h22);
        end

        // 5: drop and clear on the same edge, then a lone clear
        fillBytes(8'h40, 16);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("t5_set_wins", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t5_sticky", {31'd0, overflow}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t5_cleared", {31'd0, overflow}, 32'd0);
        drainAll();
        checkOutput("t5_count", got.size(), 32'd16);

        // 7: push and pop together with a single entry
        sendByte(8'h61, 3);
        applyStimulus(1'b1, 8'h62, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
        checkOutput("t7_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t7_data", {24'd0, out_data}, 32'h62);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        drainAll();
        checkOutput("t7_count", got.size(), 32'd1);

        // 8: push into empty FIFO with out_ready high, no bypass
        applyStimulus(1'b1, 8'h70, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h70, 1'b1, 1'b0);
        checkOutput("t8_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("t8_data", {24'd0, out_data}, 32'h70);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("t8_popped", {31'd0, out_valid}, 32'd0);

        // 6: asynchronous reset with bytes buffered
        fillBytes(8'h80, 5);
        checkOutput("t6_model_size", mq.size(), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid_async", {31'd0, out_valid}, 32'd0);
        checkOutput("t6_data_async", {24'd0, out_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sendByte(8'h99, 3);
        drainAll();
        checkOutput("t6_count", got.size(), 32'd1);
        if (got.size() == 1) checkOutput("t6_byte", {24'd0, got[0]}, 32'h99);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
